// File: rtl/gfx_pkg.sv
// -----------------------------------------------------------------------------
// gfx_pkg
// Definitions shared by the line-drawing pipeline: screen geometry, the
// framebuffer pixel address type and the write-FSM state encoding.
// -----------------------------------------------------------------------------
package gfx_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int ADDR_W   = 19;

    // Linear framebuffer address, row*SCREEN_W + col
    typedef logic [ADDR_W-1:0] pix_addr_t;

    // Single-pixel write sequencer toward the SRAM controller
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } wr_state_e;

endpackage

// File: rtl/pixel_write_buffer_if.sv
// -----------------------------------------------------------------------------
// pixel_write_buffer_if
// Bundles the generator-side pixel stream and the SRAM write handshake.
//
// Signals:
//   pix_valid / pix_addr / color / line_done : from the line generator
//   stop                                     : back-pressure to the generator
//   mem_req / mem_addr / mem_data / mem_ack  : single-pixel write handshake
//   wr_done / overflow / oob_cnt             : completion and error status
//
// Modports:
//   slave  - the pixel write buffer itself
//   master - the environment (generator plus SRAM controller)
// -----------------------------------------------------------------------------
interface pixel_write_buffer_if
    import gfx_pkg::*;
#(
    parameter int COLOR_W = 8
);

    logic               pix_valid;
    pix_addr_t          pix_addr;
    logic [COLOR_W-1:0] color;
    logic               line_done;
    logic               stop;

    logic               mem_req;
    pix_addr_t          mem_addr;
    logic [COLOR_W-1:0] mem_data;
    logic               mem_ack;

    logic               wr_done;
    logic               overflow;
    logic [7:0]         oob_cnt;

    modport slave (
        input  pix_valid, pix_addr, color, line_done, mem_ack,
        output stop, mem_req, mem_addr, mem_data, wr_done, overflow, oob_cnt
    );

    modport master (
        output pix_valid, pix_addr, color, line_done, mem_ack,
        input  stop, mem_req, mem_addr, mem_data, wr_done, overflow, oob_cnt
    );

endinterface

// File: rtl/pwb_fifo.sv
// -----------------------------------------------------------------------------
// pwb_fifo
// Synchronous FIFO with first-word-fall-through read: o_rdata always shows the
// head entry. The caller guarantees no push when full (unless popping in the
// same cycle) and no pop when empty.
//
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push       : write i_wdata at the tail
//   i_pop        : discard the head entry
//   o_rdata      : head entry
//   o_full       : DEPTH entries stored
//   o_empty      : no entries stored
//   o_count      : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module pwb_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // NOTE: the storage array is deliberately not reset; entries are only read
    // once the count says they were written, and leaving it out of reset lets
    // it map onto plain RAM/register-file cells.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/pixel_write_buffer.sv
// -----------------------------------------------------------------------------
// pixel_write_buffer
// Sits behind the Bresenham line generator. Filters the incoming pixel stream
// (out-of-range and back-to-back duplicate addresses), queues {addr, colour}
// pairs and writes them one at a time to the framebuffer SRAM controller over
// a req/ack handshake. Signals completion of a line once every pixel of that
// line has been acknowledged by memory.
//
// Ports:
//   i_clk : system clock
//   i_rst : synchronous, active-high reset
//   bus   : pixel_write_buffer_if.slave
//             in : pix_valid, pix_addr, color, line_done, mem_ack
//             out: stop, mem_req, mem_addr, mem_data, wr_done, overflow,
//                  oob_cnt
// -----------------------------------------------------------------------------
module pixel_write_buffer
    import gfx_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int SKID     = 2,
    parameter int COLOR_W  = 8,
    parameter int MAX_ADDR = SCREEN_W * SCREEN_H
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pixel_write_buffer_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = ADDR_W + COLOR_W;

    // FIFO interface
    logic [EW-1:0] w_head;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [CW-1:0] w_count_nxt;

    // Input filtering and handshake events
    logic          w_in_range;
    logic          w_dup;
    logic          w_cand;
    logic          w_push;
    logic          w_pop;
    logic          w_done_cond;

    // Write FSM
    wr_state_e     r_state;
    wr_state_e     w_state_nxt;
    logic          w_mem_req;
    pix_addr_t     w_mem_addr;
    logic [COLOR_W-1:0] w_mem_data;

    // Status registers
    pix_addr_t     r_last_addr;
    logic          r_last_vld;
    logic          r_line_pend;
    logic          r_stop;
    logic          r_wr_done;
    logic          r_overflow;
    logic [7:0]    r_oob_cnt;

    // ------------------------------------------------------------------
    // Input filtering
    // ------------------------------------------------------------------
    assign w_in_range = (bus.pix_addr < pix_addr_t'(MAX_ADDR));
    assign w_dup      = r_last_vld && (bus.pix_addr == r_last_addr);
    assign w_cand     = bus.pix_valid && w_in_range && !w_dup;
    assign w_pop      = (r_state == REQ) && bus.mem_ack;
    // A full FIFO still takes a pixel when the head is retiring this cycle
    assign w_push     = w_cand && (!w_fifo_full || w_pop);

    // Line completes once nothing is queued, nothing is in flight and no
    // pixel of the line is arriving right now.
    assign w_done_cond = r_line_pend && w_fifo_empty && (r_state == IDLE) && !w_push;

    pwb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata ({bus.pix_addr, bus.color}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        w_count_nxt = w_fifo_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = w_fifo_count + CW'(1);
            2'b01:   w_count_nxt = w_fifo_count - CW'(1);
            default: w_count_nxt = w_fifo_count;
        endcase
    end

    // ------------------------------------------------------------------
    // Write FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // Looking at the incoming push as well as the FIFO lets a pixel
            // landing in an empty FIFO raise mem_req on the very next cycle;
            // the FIFO head shows that pixel by then.
            IDLE:    if (!w_fifo_empty || w_push) w_state_nxt = REQ;
            REQ:     if (bus.mem_ack)             w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Address/data are the FIFO head, which cannot move until the ack pops
    // it, so they stay stable for the whole request. Outside REQ they read 0.
    always_comb begin
        w_mem_req  = 1'b0;
        w_mem_addr = '0;
        w_mem_data = '0;
        if (r_state == REQ) begin
            w_mem_req  = 1'b1;
            w_mem_addr = w_head[EW-1 -: ADDR_W];
            w_mem_data = w_head[COLOR_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Status and bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_addr <= '0;
            r_last_vld  <= 1'b0;
            r_line_pend <= 1'b0;
            r_stop      <= 1'b0;
            r_wr_done   <= 1'b0;
            r_overflow  <= 1'b0;
            r_oob_cnt   <= '0;
        end else begin
            // w_done_cond excludes a push, so these two never collide
            if (w_push) begin
                r_last_addr <= bus.pix_addr;
                r_last_vld  <= 1'b1;
            end else if (w_done_cond) begin
                r_last_vld  <= 1'b0;
            end

            // A line_done seen while one is already pending folds into it
            if (w_done_cond) begin
                r_line_pend <= 1'b0;
            end else if (bus.line_done) begin
                r_line_pend <= 1'b1;
            end

            r_wr_done <= w_done_cond;

            // Stop early enough that pixels still in the generator's
            // stop-to-halt window find room.
            r_stop <= (w_count_nxt >= CW'(DEPTH - SKID));

            if (w_cand && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end

            if (bus.pix_valid && !w_in_range && (r_oob_cnt != 8'hFF)) begin
                r_oob_cnt <= r_oob_cnt + 8'd1;
            end
        end
    end

    assign bus.stop     = r_stop;
    assign bus.mem_req  = w_mem_req;
    assign bus.mem_addr = w_mem_addr;
    assign bus.mem_data = w_mem_data;
    assign bus.wr_done  = r_wr_done;
    assign bus.overflow = r_overflow;
    assign bus.oob_cnt  = r_oob_cnt;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_pixel_write_buffer
// Directed stimulus for pixel_write_buffer. Each accepted pixel pushes its
// expected {addr, colour} write into a queue; a monitor retires entries as
// memory acknowledges them and also watches request stability and wr_done.
// -----------------------------------------------------------------------------
module tb_pixel_write_buffer;
    import gfx_pkg::*;

    localparam int COLOR_W = 8;

    typedef struct packed {
        pix_addr_t  addr;
        logic [7:0] data;
    } wr_t;

    typedef enum int {ACK_ON, ACK_OFF, ACK_RAND} ack_mode_e;

    logic      clk = 1'b0;
    logic      rst;
    ack_mode_e ack_mode = ACK_ON;

    int  n_checks  = 0;
    int  n_fail    = 0;
    int  n_commits = 0;
    int  n_wr_done = 0;
    wr_t exp_q[$];

    pixel_write_buffer_if #(.COLOR_W(COLOR_W)) bus ();

    pixel_write_buffer #(
        .DEPTH    (8),
        .SKID     (2),
        .COLOR_W  (COLOR_W),
        .MAX_ADDR (307200)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input pix_addr_t a, input logic [7:0] c, input bit accept);
        bus.pix_valid = 1'b1;
        bus.pix_addr  = a;
        bus.color     = c;
        if (accept) exp_q.push_back('{addr: a, data: c});
        tick();
        bus.pix_valid = 1'b0;
    endtask

    task automatic pulse_line_done();
        bus.line_done = 1'b1;
        tick();
        bus.line_done = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.pix_valid = 1'b0;
        bus.line_done = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 0);
    endtask

    // Memory-side acknowledge model
    initial begin
        int dly = 0;
        bus.mem_ack = 1'b0;
        forever begin
            tick();
            case (ack_mode)
                ACK_ON:  bus.mem_ack = 1'b1;
                ACK_OFF: bus.mem_ack = 1'b0;
                default: begin
                    if (bus.mem_ack) begin
                        bus.mem_ack = 1'b0;
                        dly = $urandom_range(0, 3);
                    end else if (bus.mem_req) begin
                        if (dly == 0) bus.mem_ack = 1'b1;
                        else          dly--;
                    end
                end
            endcase
        end
    end

    // Monitor: retires expected writes and checks handshake rules
    initial begin
        logic       prev_req  = 1'b0;
        logic       prev_ack  = 1'b0;
        pix_addr_t  prev_addr = '0;
        logic [7:0] prev_data = '0;
        wr_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (prev_req && !prev_ack) begin
                    check("req_held_without_ack", 32'(bus.mem_req), 1);
                    if (bus.mem_req) begin
                        check("addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
                        check("data_stable", 32'(bus.mem_data), 32'(prev_data));
                    end
                end
                if (bus.mem_req && bus.mem_ack) begin
                    n_commits++;
                    check("write_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                        check("wr_data", 32'(bus.mem_data), 32'(e.data));
                    end
                end
                if (bus.wr_done) begin
                    n_wr_done++;
                    check("wr_done_after_all_writes", 32'(exp_q.size()), 0);
                end
                prev_req  = bus.mem_req;
                prev_ack  = bus.mem_ack;
                prev_addr = bus.mem_addr;
                prev_data = bus.mem_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_done;
        int base_commits;

        rst           = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_addr  = '0;
        bus.color     = '0;
        bus.line_done = 1'b0;

        // ---- reset values ----
        tick();
        check("rst_mem_req",  32'(bus.mem_req),  0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_data", 32'(bus.mem_data), 0);
        check("rst_stop",     32'(bus.stop),     0);
        check("rst_wr_done",  32'(bus.wr_done),  0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_oob_cnt",  32'(bus.oob_cnt),  0);
        tick();
        rst = 1'b0;
        tick();

        // ---- single pixel, ack tied high ----
        ack_mode  = ACK_ON;
        base_done = n_wr_done;
        push(19'h00000, 8'hAA, 1'b1);
        check("single_req_next_cycle", 32'(bus.mem_req),  1);
        check("single_addr",           32'(bus.mem_addr), 0);
        check("single_data",           32'(bus.mem_data), 32'h0AA);
        pulse_line_done();
        repeat (4) tick();
        check("single_wr_done_once", 32'(n_wr_done - base_done), 1);
        check("single_drained",      32'(exp_q.size()),          0);

        // ---- back-pressure, ack held low ----
        do_reset();
        ack_mode = ACK_OFF;
        for (int i = 1; i <= 8; i++) begin
            push(pix_addr_t'(i), 8'(8'h10 + i), 1'b1);
            if (i == 5) check("bp_stop_after_5", 32'(bus.stop), 0);
            if (i == 6) check("bp_stop_after_6", 32'(bus.stop), 1);
            if (i == 8) check("bp_overflow_before_9", 32'(bus.overflow), 0);
        end
        push(19'd9, 8'h19, 1'b0);
        check("bp_overflow_after_9", 32'(bus.overflow), 1);
        base_commits = n_commits;
        ack_mode     = ACK_ON;
        wait_drain("bp_drain", 40);
        repeat (3) tick();
        check("bp_write_count",      32'(n_commits - base_commits), 8);
        check("bp_stop_released",    32'(bus.stop),                 0);
        check("bp_overflow_sticky",  32'(bus.overflow),             1);

        // ---- filtering: duplicates and out of range ----
        do_reset();
        ack_mode     = ACK_ON;
        base_commits = n_commits;
        push(19'd640,    8'h01, 1'b1);
        push(19'd640,    8'h02, 1'b0);
        push(19'd640,    8'h03, 1'b0);
        push(19'd307200, 8'h04, 1'b0);
        push(19'd641,    8'h05, 1'b1);
        wait_drain("filt_drain", 20);
        repeat (3) tick();
        check("filt_write_count", 32'(n_commits - base_commits), 2);
        check("filt_oob_cnt",     32'(bus.oob_cnt),              1);
        check("filt_overflow",    32'(bus.overflow),             0);
        // last in-range address is accepted; oob counter saturates
        push(19'd307199, 8'h5A, 1'b1);
        wait_drain("filt_edge_drain", 20);
        bus.pix_valid = 1'b1;
        bus.pix_addr  = 19'h7FFFF;
        repeat (260) tick();
        bus.pix_valid = 1'b0;
        tick();
        check("filt_oob_saturate", 32'(bus.oob_cnt), 255);

        // ---- diagonal (0,0)->(3,3) with random ack delay ----
        do_reset();
        ack_mode     = ACK_RAND;
        base_done    = n_wr_done;
        base_commits = n_commits;
        push(19'd0,    8'h31, 1'b1);
        push(19'd641,  8'h32, 1'b1);
        push(19'd1282, 8'h33, 1'b1);
        push(19'd1923, 8'h34, 1'b1);
        pulse_line_done();
        wait_drain("diag_drain", 60);
        repeat (6) tick();
        check("diag_write_count",   32'(n_commits - base_commits), 4);
        check("diag_wr_done_once",  32'(n_wr_done - base_done),    1);

        // ---- reset while a write is outstanding ----
        do_reset();
        ack_mode = ACK_OFF;
        push(19'd400000, 8'h00, 1'b0);
        push(19'd100,    8'h41, 1'b1);
        push(19'd101,    8'h42, 1'b1);
        push(19'd102,    8'h43, 1'b1);
        check("mid_in_req",      32'(bus.mem_req), 1);
        check("mid_oob_pre_rst", 32'(bus.oob_cnt), 1);
        base_done = n_wr_done;
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rst_mem_req",  32'(bus.mem_req),  0);
        check("mid_rst_stop",     32'(bus.stop),     0);
        check("mid_rst_overflow", 32'(bus.overflow), 0);
        check("mid_rst_oob_cnt",  32'(bus.oob_cnt),  0);
        rst          = 1'b0;
        ack_mode     = ACK_ON;
        base_commits = n_commits;
        repeat (10) tick();
        check("mid_fifo_empty",  32'(n_commits - base_commits), 0);
        check("mid_no_wr_done",  32'(n_wr_done - base_done),    0);

        // ---- line_done twice while busy ----
        do_reset();
        ack_mode  = ACK_OFF;
        base_done = n_wr_done;
        for (int i = 0; i < 5; i++) begin
            push(pix_addr_t'(200 + i), 8'(8'h50 + i), 1'b1);
        end
        pulse_line_done();
        tick();
        pulse_line_done();
        repeat (3) tick();
        check("busy_no_early_done", 32'(n_wr_done - base_done), 0);
        ack_mode = ACK_RAND;
        wait_drain("busy_drain", 80);
        repeat (6) tick();
        check("busy_single_done", 32'(n_wr_done - base_done), 1);
        ack_mode = ACK_ON;
        push(19'd204, 8'h77, 1'b1);
        wait_drain("busy_repush_drain", 20);
        repeat (4) tick();
        check("busy_no_extra_done", 32'(n_wr_done - base_done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
